// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module      : counter_pkg
// Description : Shared widths, types and per-cycle operation codes for the
//               modulo counter slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam int COUNT_W = 8;
    localparam int TALLY_W = 16;

    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [TALLY_W-1:0] tally_t;

    // Outcome of the reset-less priority decode for one clock edge.
    typedef enum logic [2:0] {
        CTR_HOLD,
        CTR_CLEAR,
        CTR_LOAD,
        CTR_INC,
        CTR_WRAP
    } ctr_op_e;

endpackage

`default_nettype wire

// File: rtl/inc_stage.sv
//------------------------------------------------------------------------------
// Module      : inc_stage
// Description : Combinational WIDTH-bit increment, modulo 2^WIDTH.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inc_stage
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_value + WIDTH'(1);

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
//------------------------------------------------------------------------------
// Module      : mod_counter
// Description : Registered modulo-N up-counter with terminal-count flag,
//               one-cycle wrap pulse and saturating wrap tally.
//               Define MOD_COUNTER_SATURATE_EN to clamp at limit instead of
//               wrapping to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNT_W,
    parameter int TALLY_WIDTH = TALLY_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_value,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       limit,
    output logic [WIDTH-1:0]       count,
    output logic                   tc,
    output logic                   wrap,
    output logic [TALLY_WIDTH-1:0] tally
);

    logic [WIDTH-1:0]       r_count;
    logic                   r_wrap;
    logic [TALLY_WIDTH-1:0] r_tally;
    logic [WIDTH-1:0]       w_count_inc;
    logic                   w_at_limit;
    ctr_op_e                w_op;

    inc_stage #(
        .WIDTH   (WIDTH)
    ) u_inc_stage (
        .i_value (r_count),
        .o_value (w_count_inc)
    );

    // >= rather than == so loads above limit and a lowered limit still wrap.
    assign w_at_limit = (r_count >= limit);

    always_comb begin
        w_op = CTR_HOLD;
        if (clear) begin
            w_op = CTR_CLEAR;
        end else if (load) begin
            w_op = CTR_LOAD;
        end else if (enable) begin
            w_op = w_at_limit ? CTR_WRAP : CTR_INC;
        end
    end

`ifndef MOD_COUNTER_SATURATE_EN
    logic w_tally_full;
    assign w_tally_full = &r_tally;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_tally <= '0;
        end else begin
            case (w_op)
                CTR_CLEAR: begin
                    r_count <= '0;
                    r_wrap  <= 1'b0;
                end
                CTR_LOAD: begin
                    r_count <= load_value;
                    r_wrap  <= 1'b0;
                end
                CTR_INC: begin
                    r_count <= w_count_inc;
                    r_wrap  <= 1'b0;
                end
                CTR_WRAP: begin
`ifdef MOD_COUNTER_SATURATE_EN
                    r_count <= limit;
                    r_wrap  <= 1'b0;
`else
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                    if (!w_tally_full) begin
                        r_tally <= r_tally + TALLY_WIDTH'(1);
                    end
`endif
                end
                default: begin
                    r_wrap <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign tc    = w_at_limit;
    assign wrap  = r_wrap;
    assign tally = r_tally;

endmodule

`default_nettype wire
